pipeline_hazard_ctrl: RTL and testbench

- Central hazard controller for the 16-bit 5-stage pipeline.
- Drives stall and flush to the IF/ID, ID/EX, EX/ME and ME/WB pipeline registers, and forwarding selects to the EX operand muxes.
- Sequences multi-cycle data-memory accesses in MEM with a wait/timeout FSM.
- Keeps a saturating stall-cycle counter for performance visibility.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv | 68 ++++++
 rtl/pipeline_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// MEM wait FSM states and EX operand forward selects.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MEM_ERR
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bundle between the 5-stage datapath and its controller.
// master = datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] RsD, RtD;
  logic [REG_AW-1:0] RsE, RtE, RdE;
  logic              RegWriteE, MemToRegE, PCSrcE;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteM, MemReqM, MemReadyM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteW;

  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MemErr;
  logic [CNT_W-1:0]  StallCycles;

  modport master (
    output RsD, RtD, RsE, RtE, RdE,
    output RegWriteE, MemToRegE, PCSrcE,
    output RdM, RegWriteM, MemReqM, MemReadyM,
    output RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  MemErr, StallCycles
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, RdE,
    input  RegWriteE, MemToRegE, PCSrcE,
    input  RdM, RegWriteM, MemReqM, MemReadyM,
    input  RdW, RegWriteW,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output MemErr, StallCycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// MEM-stage wait/timeout sequencer for multi-cycle data accesses.
// Owns state, wait counter, sticky error and the memory-stall term.
module mem_wait_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic memReq,
  input  logic memReady,
  output logic memStall,
  output logic inRun,
  output logic memErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t          state, nextState;
  logic [CW-1:0]   waitCnt, nextCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
      if (nextState == MEM_ERR)
        memErr <= 1'b1;
    end
  end

  // waitCnt counts every stalled cycle of the access, the entry one included
  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    memStall  = 1'b0;
    unique case (state)
      RUN: begin
        nextCnt = '0;
        if (memReq && !memReady) begin
          nextState = MEM_WAIT;
          nextCnt   = CW'(1);
          memStall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          nextState = RUN;
          nextCnt   = '0;
        end else begin
          memStall = 1'b1;
          nextCnt  = waitCnt + CW'(1);
          if (waitCnt == LAST)
            nextState = MEM_ERR;
        end
      end
      MEM_ERR: memStall = 1'b1;
      default: nextState = RUN;
    endcase
  end

  assign inRun = (state == RUN);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: stalls, flushes, forwarding
// and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 1
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);

  logic memStall, inRun, memErr;
  logic loadUse, branch, ldHit, rdE0;
  logic stallF;
  logic [1:0] fwdA, fwdB;
  logic [CNT_W-1:0] stallCnt;

  mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .memReq   (hz.MemReqM),
    .memReady (hz.MemReadyM),
    .memStall (memStall),
    .inRun    (inRun),
    .memErr   (memErr)
  );

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic              rwM,
    input logic [REG_AW-1:0] rdW,
    input logic              rwW
  );
    logic zero, hitM, hitW;
    zero = (R0_ZERO != 0) && (rs == '0);
    hitM = !zero && rwM && (rdM == rs);
    hitW = !zero && !hitM && rwW && (rdW == rs);
    unique case (1'b1)
      hitM:    return FWD_MEM;
      hitW:    return FWD_WB;
      default: return FWD_RF;
    endcase
  endfunction

  always_comb begin
    fwdA = fwdSel(hz.RsE, hz.RdM, hz.RegWriteM,
                  hz.RdW, hz.RegWriteW);
    fwdB = fwdSel(hz.RtE, hz.RdM, hz.RegWriteM,
                  hz.RdW, hz.RegWriteW);
  end

  assign rdE0    = (R0_ZERO != 0) && (hz.RdE == '0);
  assign ldHit   = (hz.RdE == hz.RsD) || (hz.RdE == hz.RtD);
  assign loadUse = inRun && !memStall && hz.MemToRegE
                && hz.RegWriteE && ldHit && !rdE0;
  assign branch  = hz.PCSrcE && !memStall;

  // memory stall beats branch, branch beats load-use
  assign stallF = !reset
               && (memStall || (loadUse && !branch));

  assign hz.StallF = stallF;
  assign hz.StallD = stallF;
  assign hz.StallE = !reset && memStall;
  assign hz.StallM = !reset && memStall;
  assign hz.FlushD = !reset && branch;
  assign hz.FlushE = !reset && (branch || loadUse);
  assign hz.FlushW = !reset && memStall;
  assign hz.ForwardAE = reset ? FWD_RF : fwdA;
  assign hz.ForwardBE = reset ? FWD_RF : fwdB;
  assign hz.MemErr = memErr;
  assign hz.StallCycles = stallCnt;

  always_ff @(posedge clk) begin
    if (reset)
      stallCnt <= '0;
    else if (stallF && !(&stallCnt))
      stallCnt <= stallCnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Inputs change 1 time unit after posedge; checks follow 1 unit later.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass = 0;
  int   total = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(3), .CNT_W(16)) hz ();

  pipeline_hazard_ctrl #(
    .REG_AW(3), .TIMEOUT(16), .CNT_W(16), .R0_ZERO(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  wire [6:0] ctl = {hz.StallF, hz.StallD, hz.StallE,
                    hz.StallM, hz.FlushD, hz.FlushE,
                    hz.FlushW};

  task automatic idle();
    hz.RsD = '0; hz.RtD = '0;
    hz.RsE = '0; hz.RtE = '0; hz.RdE = '0;
    hz.RegWriteE = 0; hz.MemToRegE = 0; hz.PCSrcE = 0;
    hz.RdM = '0; hz.RegWriteM = 0;
    hz.MemReqM = 0; hz.MemReadyM = 0;
    hz.RdW = '0; hz.RegWriteW = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    hz.MemReqM = 1; hz.PCSrcE = 1;
    hz.RsE = 3'd2; hz.RdM = 3'd2; hz.RegWriteM = 1;
    #1;
    total++;
    if (ctl !== 7'b0)
      $display("FAIL rst_ctl got %b want %b", ctl, 7'b0);
    else pass++;
    total++;
    if (hz.ForwardAE !== 2'b00)
      $display("FAIL rst_fwdA got %b want 00", hz.ForwardAE);
    else pass++;
    tick(); tick();
    reset = 1'b0;
    idle();
    #1;
    total++;
    if (hz.MemErr !== 1'b0 || hz.StallCycles !== 16'd0)
      $display("FAIL rst_state got err=%b cnt=%0d want 0/0",
               hz.MemErr, hz.StallCycles);
    else pass++;
  endtask

  task automatic test_zero_wait();
    hz.MemReqM = 1; hz.MemReadyM = 1;
    #1;
    total++;
    if (ctl !== 7'b0)
      $display("FAIL zw_ctl got %b want %b", ctl, 7'b0);
    else pass++;
    tick();
    idle();
    #1;
    total++;
    if (hz.StallCycles !== 16'd0)
      $display("FAIL zw_cnt got %0d want 0", hz.StallCycles);
    else pass++;
  endtask

  task automatic test_three_wait();
    hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctl !== 7'b1111001)
        $display("FAIL wait3_c%0d got %b want %b", i, ctl,
                 7'b1111001);
      else pass++;
      tick();
    end
    hz.MemReadyM = 1;
    #1;
    total++;
    if (ctl !== 7'b0)
      $display("FAIL wait3_ready got %b want %b", ctl, 7'b0);
    else pass++;
    tick();
    idle();
    #1;
    total++;
    if (hz.StallCycles !== 16'd3 || ctl !== 7'b0)
      $display("FAIL wait3_cnt got %0d/%b want 3/0",
               hz.StallCycles, ctl);
    else pass++;
  endtask

  task automatic test_load_use();
    hz.MemToRegE = 1; hz.RegWriteE = 1;
    hz.RdE = 3'd3; hz.RsD = 3'd3;
    #1;
    total++;
    if (ctl !== 7'b1100010)
      $display("FAIL lu_ctl got %b want %b", ctl, 7'b1100010);
    else pass++;
    tick();
    hz.MemToRegE = 0; hz.RegWriteE = 0;
    #1;
    total++;
    if (ctl !== 7'b0 || hz.StallCycles !== 16'd4)
      $display("FAIL lu_bubble got %b/%0d want 0/4", ctl,
               hz.StallCycles);
    else pass++;
    hz.MemToRegE = 1; hz.RegWriteE = 1;
    hz.RdE = 3'd0; hz.RsD = 3'd0;
    #1;
    total++;
    if (ctl !== 7'b0)
      $display("FAIL lu_r0 got %b want %b", ctl, 7'b0);
    else pass++;
    idle();
  endtask

  task automatic test_branch();
    hz.MemToRegE = 1; hz.RegWriteE = 1;
    hz.RdE = 3'd3; hz.RtD = 3'd3; hz.PCSrcE = 1;
    #1;
    total++;
    if (ctl !== 7'b0000110)
      $display("FAIL br_lu got %b want %b", ctl, 7'b0000110);
    else pass++;
    hz.MemReqM = 1; hz.MemReadyM = 0;
    #1;
    total++;
    if (ctl !== 7'b1111001)
      $display("FAIL br_memrun got %b want %b", ctl,
               7'b1111001);
    else pass++;
    tick();
    total++;
    if (ctl !== 7'b1111001)
      $display("FAIL br_memwait got %b want %b", ctl,
               7'b1111001);
    else pass++;
    hz.MemReadyM = 1;
    #1;
    total++;
    if (ctl !== 7'b0000110)
      $display("FAIL br_release got %b want %b", ctl,
               7'b0000110);
    else pass++;
    tick();
    idle();
    #1;
    total++;
    if (hz.StallCycles !== 16'd5)
      $display("FAIL br_cnt got %0d want 5", hz.StallCycles);
    else pass++;
  endtask

  task automatic test_forward();
    hz.RsE = 3'd2; hz.RdM = 3'd2; hz.RegWriteM = 1;
    hz.RdW = 3'd2; hz.RegWriteW = 1; hz.RtE = 3'd5;
    #1;
    total++;
    if (hz.ForwardAE !== 2'b10)
      $display("FAIL fwd_mem got %b want 10", hz.ForwardAE);
    else pass++;
    total++;
    if (hz.ForwardBE !== 2'b00)
      $display("FAIL fwd_none got %b want 00", hz.ForwardBE);
    else pass++;
    hz.RegWriteM = 0;
    #1;
    total++;
    if (hz.ForwardAE !== 2'b01)
      $display("FAIL fwd_wb got %b want 01", hz.ForwardAE);
    else pass++;
    hz.RtE = 3'd5; hz.RdM = 3'd5; hz.RegWriteM = 1;
    #1;
    total++;
    if (hz.ForwardBE !== 2'b10 || hz.ForwardAE !== 2'b01)
      $display("FAIL fwd_bmem got %b/%b want 10/01",
               hz.ForwardBE, hz.ForwardAE);
    else pass++;
    hz.RsE = 3'd0; hz.RdM = 3'd0; hz.RdW = 3'd0;
    #1;
    total++;
    if (hz.ForwardAE !== 2'b00)
      $display("FAIL fwd_r0 got %b want 00", hz.ForwardAE);
    else pass++;
    idle();
  endtask

  task automatic test_timeout();
    hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      total++;
      if (hz.StallF !== 1'b1 || hz.MemErr !== 1'b0)
        $display("FAIL to_c%0d got stall=%b err=%b want 1/0",
                 i, hz.StallF, hz.MemErr);
      else pass++;
      tick();
    end
    total++;
    if (hz.MemErr !== 1'b1 || hz.StallCycles !== 16'd21)
      $display("FAIL to_err got %b/%0d want 1/21",
               hz.MemErr, hz.StallCycles);
    else pass++;
    hz.MemReadyM = 1;
    #1;
    total++;
    if (ctl !== 7'b1111001)
      $display("FAIL to_hold got %b want %b", ctl, 7'b1111001);
    else pass++;
    tick(); tick(); tick();
    total++;
    if (hz.MemErr !== 1'b1 || hz.StallCycles !== 16'd24)
      $display("FAIL to_sticky got %b/%0d want 1/24",
               hz.MemErr, hz.StallCycles);
    else pass++;
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== 7'b0)
      $display("FAIL to_rstctl got %b want %b", ctl, 7'b0);
    else pass++;
    tick();
    reset = 1'b0;
    idle();
    #1;
    total++;
    if (hz.MemErr !== 1'b0 || hz.StallCycles !== 16'd0
        || ctl !== 7'b0)
      $display("FAIL to_clear got %b/%0d/%b want 0/0/0",
               hz.MemErr, hz.StallCycles, ctl);
    else pass++;
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    tick();
    test_zero_wait();
    tick();
    test_three_wait();
    tick();
    test_load_use();
    tick();
    test_branch();
    tick();
    test_forward();
    tick();
    test_timeout();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
